// File: rtl/led_breath.sv
// LED pattern generator for LEDR: off, on, blink or a triangle-ramped PWM "breathe".
// Prescaler, PWM slot counter, step counter and duty ramp free-run in every mode.
module led_breath #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 375,
  parameter int STEP_PERIODS = 4,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [1:0]          MODE,
  output logic                LEDR,
  output logic [PWM_BITS-1:0] DUTY,
  output logic                PWM_WRAP
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [STP_W-1:0]    STP_LAST = STP_W'(STEP_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
  localparam logic                UNLIT    = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_slot;
  logic [STP_W-1:0]    r_stp;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_up;
  logic                r_ledr;
  logic                r_wrap;

  logic w_tick;
  logic w_wrap;
  logic w_step;
  logic w_lit;

  assign w_tick = (r_pre == PRE_LAST);
  assign w_wrap = w_tick && (r_slot == DUTY_MAX);
  assign w_step = w_wrap && (r_stp == STP_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre  <= '0;
      r_slot <= '0;
      r_stp  <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) r_slot <= r_slot + DUTY_ONE;
      if (w_wrap) r_stp <= w_step ? '0 : r_stp + STP_W'(1);
    end
  end

  // Direction flips on the step that lands on an end point, so the ramp never wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_duty <= '0;
      r_up   <= 1'b1;
    end else if (w_step) begin
      if (r_up) begin
        r_duty <= r_duty + DUTY_ONE;
        if (r_duty == DUTY_MAX - DUTY_ONE) r_up <= 1'b0;
      end else begin
        r_duty <= r_duty - DUTY_ONE;
        if (r_duty == DUTY_ONE) r_up <= 1'b1;
      end
    end
  end

  always_comb begin
    w_lit = 1'b0;
    case (MODE)
      2'b00:   w_lit = 1'b0;
      2'b01:   w_lit = 1'b1;
      2'b10:   w_lit = r_up;
      default: w_lit = (r_slot < r_duty);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ledr <= UNLIT;
      r_wrap <= 1'b0;
    end else begin
      r_ledr <= w_lit ^ UNLIT;
      r_wrap <= w_wrap;
    end
  end

  assign LEDR     = r_ledr;
  assign DUTY     = r_duty;
  assign PWM_WRAP = r_wrap;

endmodule

// File: tb/tb_led_breath.sv
// Bench for led_breath: closed-form model of the ramp/PWM timeline plus directed literal checks.
module tb_led_breath;

  localparam int PWM_BITS = 3;
  localparam int PRESCALE = 2;
  localparam int STEPS    = 1;
  localparam int SLOTS    = 2 ** PWM_BITS;
  localparam int MAXD     = SLOTS - 1;
  localparam int STEP_CYC = SLOTS * PRESCALE * STEPS;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [1:0]          MODE;
  logic [1:0]          MODE_AL;
  logic                LEDR, LEDR_AL;
  logic [PWM_BITS-1:0] DUTY, DUTY_AL;
  logic                PWM_WRAP, PWM_WRAP_AL;

  int checks   = 0;
  int failures = 0;

  led_breath #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .STEP_PERIODS(STEPS), .ACTIVE_LOW(0)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .LEDR(LEDR), .DUTY(DUTY), .PWM_WRAP(PWM_WRAP));

  led_breath #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .STEP_PERIODS(STEPS), .ACTIVE_LOW(1)) u_dut_al (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE_AL), .LEDR(LEDR_AL), .DUTY(DUTY_AL), .PWM_WRAP(PWM_WRAP_AL));

  always #5 CLK = ~CLK;

  // Model: everything is a function of k, the number of clock edges since reset release.
  function automatic int duty_of(int k);
    int m;
    m = (k / STEP_CYC) % (2 * MAXD);
    return (m <= MAXD) ? m : 2 * MAXD - m;
  endfunction

  function automatic int up_of(int k);
    return (((k / STEP_CYC) % (2 * MAXD)) < MAXD) ? 1 : 0;
  endfunction

  function automatic int lit_of(int k, logic [1:0] mode);
    case (mode)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b10:   return up_of(k);
      default: return (((k / PRESCALE) % SLOTS) < duty_of(k)) ? 1 : 0;
    endcase
  endfunction

  function automatic int wrap_of(int k);
    return (k > 0 && (k % STEP_CYC) == 0) ? 1 : 0;
  endfunction

  int k          = 0;
  int exp_ledr   = 0;
  int exp_ledr_a = 1;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k          = 0;
      exp_ledr   = 0;
      exp_ledr_a = 1;
    end else begin
      exp_ledr   = lit_of(k, MODE);
      exp_ledr_a = 1 - lit_of(k, MODE_AL);
      k          = k + 1;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d k=%0d t=%0t", name, act, req, k, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("ledr",    int'(LEDR),        exp_ledr);
    chk("duty",    int'(DUTY),        duty_of(k));
    chk("wrap",    int'(PWM_WRAP),    wrap_of(k));
    chk("ledr_al", int'(LEDR_AL),     exp_ledr_a);
    chk("duty_al", int'(DUTY_AL),     duty_of(k));
    chk("wrap_al", int'(PWM_WRAP_AL), wrap_of(k));
  end

  int seq [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int cnt;
  int wraps;

  initial begin
    RST_N   = 1'b0;
    MODE    = 2'b11;
    MODE_AL = 2'b10;

    repeat (3) begin
      @(negedge CLK);
      chk("rst_ledr",    int'(LEDR),     0);
      chk("rst_duty",    int'(DUTY),     0);
      chk("rst_wrap",    int'(PWM_WRAP), 0);
      chk("rst_ledr_al", int'(LEDR_AL),  1);
    end

    RST_N = 1'b1;
    MODE  = 2'b01;
    @(negedge CLK);
    chk("mode_on", int'(LEDR), 1);
    MODE = 2'b00;
    @(negedge CLK);
    chk("mode_off", int'(LEDR), 0);
    MODE = 2'b11;

    repeat (14) @(negedge CLK);
    chk("duty_first_step", int'(DUTY), 1);

    repeat (32) @(negedge CLK);
    chk("duty_is_3", int'(DUTY), 3);
    cnt = 0;
    repeat (16) begin
      @(negedge CLK);
      cnt += int'(LEDR);
    end
    chk("lit_cycles_duty3", cnt, 6);

    wraps = 0;
    while (k < 240) begin
      @(negedge CLK);
      wraps += int'(PWM_WRAP);
      if ((k % STEP_CYC) == 0) chk("duty_seq", int'(DUTY), seq[k / STEP_CYC]);
      if (k == 100) chk("blink_al_up", int'(LEDR_AL), 0);
      if (k == 130) chk("blink_al_down", int'(LEDR_AL), 1);
    end
    chk("wrap_pulses", wraps, 11);

    repeat (130) @(negedge CLK);
    chk("pre_reset_duty5", int'(DUTY), 5);
    #2 RST_N = 1'b0;
    #1;
    chk("async_ledr",    int'(LEDR),     0);
    chk("async_duty",    int'(DUTY),     0);
    chk("async_wrap",    int'(PWM_WRAP), 0);
    chk("async_ledr_al", int'(LEDR_AL),  1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (16) @(negedge CLK);
    chk("restart_duty1", int'(DUTY), 1);
    repeat (16) @(negedge CLK);
    chk("restart_duty2", int'(DUTY), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
